// File: rtl/burst_sequencer.sv
// burst_sequencer
//   Arbitrates two requesters onto a shared burst link and sequences one burst
//   at a time. It waits a bounded number of cycles for the master to go ready,
//   counts BURST_LEN beats (cycles where neither master nor slave is busy),
//   tolerates up to GRANT_WAIT-1 consecutive stall cycles, then completes
//   (done) or times out (abort) and returns the link to idle.
//
// Optional feature macro: BURST_SEQ_RR_EN
//   defined   : round-robin arbitration, last winner gets lowest priority.
//   undefined : fixed priority, req[0] always wins; no pointer state.
//
// Handshake: req[i] is a level held by requester i until it sees done[i] or
//   abort. gnt is one-hot and held for the whole burst. done/abort are
//   registered single-cycle pulses. beat is combinational and only ever high
//   in XFER, when master_busy and slave_busy are both low.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   req[1:0]       : burst request per requester
//   master_busy    : master not ready
//   slave_busy     : slave not ready
//   gnt[1:0]       : one-hot grant (registered)
//   burst_enable   : burst in progress (registered)
//   beat           : a beat transfers this cycle (combinational)
//   beat_cnt       : beats completed in current burst (registered)
//   done[1:0]      : completion pulse to the granted requester
//   abort          : timeout pulse
//   state_dbg[1:0] : current FSM state, for observation only
module burst_sequencer #(
  parameter int BURST_LEN  = 6,
  parameter int GRANT_WAIT = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic             master_busy,
  input  logic             slave_busy,
  output logic [1:0]       gnt,
  output logic             burst_enable,
  output logic             beat,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [1:0]       done,
  output logic             abort,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_M = 2'd1;
  localparam logic [1:0] S_XFER   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] GW_MAX   = CNT_W'(GRANT_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  // Shared counter: wait cycles in WAIT_M, consecutive stall cycles in XFER.
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       done_q, done_d;
  logic             abort_q, abort_d;
  logic [1:0]       winner;
  logic             beat_now;

`ifdef BURST_SEQ_RR_EN
  // 0: req[0] favoured on contention, 1: req[1] favoured.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    winner = 2'b00;
    if (req == 2'b11)  winner = rr_ptr_q ? 2'b10 : 2'b01;
    else if (req[0])   winner = 2'b01;
    else if (req[1])   winner = 2'b10;
  end
`else
  always_comb begin
    winner = 2'b00;
    if (req[0])        winner = 2'b01;
    else if (req[1])   winner = 2'b10;
  end
`endif

  assign beat_now = (state_q == S_XFER) && !master_busy && !slave_busy;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    en_d       = en_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 2'b00;
    abort_d    = 1'b0;
`ifdef BURST_SEQ_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d      = winner;
          en_d       = 1'b1;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
          state_d    = S_WAIT_M;
        end
      end
      S_WAIT_M: begin
        if (!master_busy) begin
          // The first ready cycle only opens the transfer; it is not a beat.
          wait_cnt_d = '0;
          state_d    = S_XFER;
        end else if (wait_cnt_q == GW_MAX) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          en_d    = 1'b0;
          abort_d = 1'b1;
`ifdef BURST_SEQ_RR_EN
          rr_ptr_d = gnt_q[0];
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_XFER: begin
        if (beat_now) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          wait_cnt_d = '0;
          if (beat_cnt_q == LAST_CNT) begin
            // Outputs are registered, so drop the link and raise done now to
            // have them take effect during the DONE cycle.
            state_d = S_DONE;
            gnt_d   = 2'b00;
            en_d    = 1'b0;
            done_d  = gnt_q;
`ifdef BURST_SEQ_RR_EN
            rr_ptr_d = gnt_q[0];
`endif
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
          if ((wait_cnt_q + CNT_ONE) == GW_MAX) begin
            // beat_cnt is left as-is so the partial count stays visible.
            state_d = S_IDLE;
            gnt_d   = 2'b00;
            en_d    = 1'b0;
            abort_d = 1'b1;
`ifdef BURST_SEQ_RR_EN
            rr_ptr_d = gnt_q[0];
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      en_q       <= 1'b0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      done_q     <= 2'b00;
      abort_q    <= 1'b0;
`ifdef BURST_SEQ_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      en_q       <= en_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
`ifdef BURST_SEQ_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign burst_enable = en_q;
  assign beat         = beat_now;
  assign beat_cnt     = beat_cnt_q;
  assign done         = done_q;
  assign abort        = abort_q;
  assign state_dbg    = state_q;

endmodule
